noc_recv_endpoint: RTL and testbench
====================================

Name: noc_recv_endpoint

Overview:
- Ejection-side endpoint attached to one receive port of the 4-node simple network (flit 21 bits, 2 VCs).
- Every cycle it pulls flits from the network receive port into per-VC buffers and reports per-VC non-full status back to the network.
- It delivers packets to the local client over a valid/ready interface, with packet-atomic round-robin arbitration between the VCs.

Parameters:
- DEPTH, 4, flit slots per VC FIFO; power of two, minimum 2.
- NODE_ID, 0, 2-bit node ID of this endpoint; used only by the optional check.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- net_get_en  out  1  drives the network's getFlit enable for this receive port.
- net_flit  in  21  getFlit data. [20] valid, [19] tail, [18:17] dest, [16] vc, [15:0] payload.
- net_nonfull_en  out  1  drives the network's putNonFullVCs enable.
- net_nonfull  out  2  putNonFullVCs data; bit v=1 means VC v can accept a flit.
- out_valid  out  1  client flit available.
- out_data  out  16  payload of the presented flit.
- out_vc  out  1  VC of the presented flit.
- out_tail  out  1  presented flit is a packet tail.
- out_ready  in  1  client accepts the flit when out_valid && out_ready.
- err_overflow  out  1  sticky: a flit arrived for a full VC.
- err_dest  out  1  sticky: dest mismatch (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (RST=1, asynchronous):
  - All FIFOs empty; arbiter in IDLE; round-robin pointer = VC0.
  - Outputs: net_get_en=0, net_nonfull_en=0, net_nonfull=2'b00, out_valid=0, out_data/out_vc/out_tail=0, both error flags=0.
- After reset: net_get_en=1 and net_nonfull_en=1 every cycle.
- Ingress: a flit is accepted when net_get_en && net_flit[20]. It is written to FIFO[net_flit[16]] at the clock edge. Flits with [20]=0 are ignored.
- Overflow: if the target FIFO is full and is not popped in the same cycle, the flit is dropped, err_overflow is set and holds until reset.
- Simultaneous push and pop on the same VC: both occur and the count is unchanged. This is legal even when the FIFO is full.
- net_nonfull[v] is combinational from registered occupancy: 1 iff free slots in FIFO v >= 2. The spare slot covers one flit in flight during the report lag.
- Latency: a flit accepted at edge N is presentable on out_* in the cycle after edge N (1 cycle minimum). The FIFO is first-word-fall-through.
- Arbiter, state IDLE:
  - Select a VC by round-robin starting at the pointer (skip empty FIFOs). out_valid=1 if any FIFO is non-empty.
  - On handshake of a non-tail flit: go to LOCKED(sel).
  - On handshake of a tail flit: stay in IDLE.
  - Every handshake sets pointer = sel+1 (mod 2).
- Arbiter, state LOCKED(v):
  - Present only FIFO v. out_valid = FIFO v non-empty; the other VC waits even if it has data.
  - On handshake of a tail: go to IDLE and set pointer = v+1.
- Hold rule: out_data/out_vc/out_tail must stay stable while out_valid && !out_ready. Selection does not change in IDLE while an unaccepted flit is presented (selection is registered at first presentation).
- Wrap-around: FIFO read/write pointers are log2(DEPTH) bits with an extra wrap bit; full/empty are derived from them.

Optional Feature:
- Macro: NOC_RECV_DEST_CHECK_EN.
- Defined: each accepted flit whose [18:17] != NODE_ID is still buffered, and err_dest is set sticky.
- Undefined: no comparison is made and err_dest is tied to 0.

Test Plan:
- Reset check: hold RST=1 for 3 cycles, then release. During reset net_nonfull=00, out_valid=0, net_get_en=0. On the first cycle after release: net_get_en=1 and net_nonfull=11.
- Single flit: inject a flit with valid=1, tail=1, vc=0, payload 0xBEEF with out_ready=1. One cycle later: out_valid=1, out_data=0xBEEF, out_vc=0, out_tail=1. Next cycle: out_valid=0.
- Packet atomicity: inject a 3-flit packet on VC1 (payloads 1, 2, 3; tail on 3) interleaved cycle-by-cycle with a 1-flit packet on VC0 (0xA0). Required client order: 1, 2, 3, 0xA0 (or 0xA0 first if VC0 wins the IDLE arbitration). No interleaving inside the VC1 packet.
- Backpressure and non-full: hold out_ready=0 and inject on VC0 until count=3 (DEPTH=4). net_nonfull[0] drops to 0 when count=3, net_nonfull[1] stays 1. A 4th flit fills the FIFO with err_overflow=0. A 5th flit sets err_overflow=1, and the FIFO contents are unchanged.
- Simultaneous push and pop with FIFO full and out_ready=1: occupancy stays at 4, FIFO order is preserved, and no overflow flag is raised.
- Reset mid-packet: assert RST in LOCKED(1) with 2 flits buffered. Outputs go to reset values immediately, and buffers are empty after release. A new packet on VC0 is then delivered normally.

Source files
------------

// File: rtl/noc_recv_endpoint.sv
// Ejection endpoint: buffers network flits per VC and delivers whole packets to the client, round-robin across VCs.
// Optional destination check enabled by defining NOC_RECV_DEST_CHECK_EN.
module noc_recv_endpoint #(
    parameter int          DEPTH   = 4,
    parameter logic [1:0]  NODE_ID = 2'd0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        net_get_en,
    input  logic [20:0] net_flit,
    output logic        net_nonfull_en,
    output logic [1:0]  net_nonfull,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_vc,
    output logic        out_tail,
    input  logic        out_ready,
    output logic        err_overflow,
    output logic        err_dest
);
    // state  | meaning
    // IDLE   | round-robin between VCs, selection held while an offer is pending
    // LOCKED | mid-packet, only lockVc is presented until its tail is taken

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO     = (AW+1)'(2);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic {IDLE, LOCKED} arbState_t;

    arbState_t   state, stateNext;
    logic        lockVc, lockVcNext;
    logic        rrPtr, rrNext;
    logic        holdValid, holdNext;
    logic        holdVc, holdVcNext;
    logic        running;

    logic [AW:0] wrPtr [2];
    logic [AW:0] rdPtr [2];
    logic [AW:0] freeSlots [2];
    logic [16:0] mem [2][DEPTH];

    logic [1:0]  empty, full, pop;
    logic        sel, selValid, handshake;
    logic [16:0] head;
    logic        inValid, pushVc, accept, overflow;

    assign net_get_en     = running;
    assign net_nonfull_en = running;
    assign inValid        = running && net_flit[20];
    assign pushVc         = net_flit[16];
    // A full FIFO still takes a flit when its head leaves in the same cycle.
    assign overflow       = inValid && full[pushVc] && !pop[pushVc];
    assign accept         = inValid && !overflow;

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            empty[v]       = (wrPtr[v] == rdPtr[v]);
            full[v]        = (wrPtr[v][AW] != rdPtr[v][AW]) &&
                             (wrPtr[v][AW-1:0] == rdPtr[v][AW-1:0]);
            freeSlots[v]   = DEPTH_W - (wrPtr[v] - rdPtr[v]);
            net_nonfull[v] = running && (freeSlots[v] >= TWO);
        end
    end

    always_comb begin
        stateNext  = state;
        lockVcNext = lockVc;
        rrNext     = rrPtr;
        holdNext   = holdValid;
        holdVcNext = holdVc;
        sel        = 1'b0;
        selValid   = 1'b0;
        pop        = 2'b00;

        if (state == LOCKED) begin
            sel      = lockVc;
            selValid = !empty[lockVc];
        end else if (holdValid) begin
            sel      = holdVc;
            selValid = 1'b1;
        end else begin
            sel      = empty[rrPtr] ? !rrPtr : rrPtr;
            selValid = |(~empty);
        end

        head      = mem[sel][rdPtr[sel][AW-1:0]];
        handshake = selValid && out_ready;
        if (handshake) begin
            pop[sel] = 1'b1;
        end

        if (handshake) begin
            holdNext = 1'b0;
            if (state == IDLE) begin
                rrNext = !sel;
                if (!head[16]) begin
                    stateNext  = LOCKED;
                    lockVcNext = sel;
                end
            end else if (head[16]) begin
                rrNext    = !lockVc;
                stateNext = IDLE;
            end
        end else if (state == IDLE && selValid) begin
            holdNext   = 1'b1;
            holdVcNext = sel;
        end

        out_valid = selValid;
        out_vc    = selValid ? sel : 1'b0;
        out_tail  = selValid ? head[16] : 1'b0;
        out_data  = selValid ? head[15:0] : 16'h0000;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lockVc    <= 1'b0;
            rrPtr     <= 1'b0;
            holdValid <= 1'b0;
            holdVc    <= 1'b0;
        end else begin
            state     <= stateNext;
            lockVc    <= lockVcNext;
            rrPtr     <= rrNext;
            holdValid <= holdNext;
            holdVc    <= holdVcNext;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            running      <= 1'b0;
            err_overflow <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                wrPtr[v] <= '0;
                rdPtr[v] <= '0;
            end
        end else begin
            running      <= 1'b1;
            err_overflow <= err_overflow | overflow;
            for (int v = 0; v < 2; v++) begin
                if (accept && (pushVc == 1'(v))) begin
                    wrPtr[v] <= wrPtr[v] + ONE;
                end
                if (pop[v]) begin
                    rdPtr[v] <= rdPtr[v] + ONE;
                end
            end
        end
    end

    // Storage carries no reset; occupancy pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[pushVc][wrPtr[pushVc][AW-1:0]] <= {net_flit[19], net_flit[15:0]};
        end
    end

`ifdef NOC_RECV_DEST_CHECK_EN
    logic errDestReg;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            errDestReg <= 1'b0;
        end else if (inValid && (net_flit[18:17] != NODE_ID)) begin
            errDestReg <= 1'b1;
        end
    end
    assign err_dest = errDestReg;
`else
    logic [1:0] unusedDest;
    assign unusedDest = net_flit[18:17] ^ NODE_ID;
    assign err_dest   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_recv_endpoint.sv
// Directed bench for noc_recv_endpoint: reset, FWFT latency, packet atomicity, backpressure, overflow, reset mid-packet.
module tb_noc_recv_endpoint;

    logic        CLK;
    logic        RST;
    logic        net_get_en;
    logic [20:0] net_flit;
    logic        net_nonfull_en;
    logic [1:0]  net_nonfull;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_vc;
    logic        out_tail;
    logic        out_ready;
    logic        err_overflow;
    logic        err_dest;

    int checks = 0;
    int errors = 0;

    noc_recv_endpoint #(.DEPTH(4), .NODE_ID(2'd0)) dut (
        .CLK(CLK),
        .RST(RST),
        .net_get_en(net_get_en),
        .net_flit(net_flit),
        .net_nonfull_en(net_nonfull_en),
        .net_nonfull(net_nonfull),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_vc(out_vc),
        .out_tail(out_tail),
        .out_ready(out_ready),
        .err_overflow(err_overflow),
        .err_dest(err_dest)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] mk(input logic tail, input logic vc, input logic [15:0] pay);
        return {1'b1, tail, 2'b00, vc, pay};
    endfunction

    initial begin
        RST       = 1'b1;
        net_flit  = '0;
        out_ready = 1'b0;

        repeat (3) step();
        chk("rst_get_en",     32'(net_get_en), 0);
        chk("rst_nonfull_en", 32'(net_nonfull_en), 0);
        chk("rst_nonfull",    32'(net_nonfull), 0);
        chk("rst_valid",      32'(out_valid), 0);
        chk("rst_data",       32'(out_data), 0);
        chk("rst_ovf",        32'(err_overflow), 0);
        chk("rst_dest",       32'(err_dest), 0);

        RST = 1'b0;
        step();
        chk("run_get_en",     32'(net_get_en), 1);
        chk("run_nonfull_en", 32'(net_nonfull_en), 1);
        chk("run_nonfull",    32'(net_nonfull), 3);
        chk("run_valid",      32'(out_valid), 0);

        // single flit, one-cycle latency
        out_ready = 1'b1;
        net_flit  = mk(1'b1, 1'b0, 16'hBEEF);
        step();
        net_flit = '0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data",  32'(out_data), 32'hBEEF);
        chk("single_vc",    32'(out_vc), 0);
        chk("single_tail",  32'(out_tail), 1);
        step();
        chk("single_gone",  32'(out_valid), 0);

        // VC1 three-flit packet interleaved with VC0 single flit
        out_ready = 1'b0;
        net_flit = mk(1'b0, 1'b1, 16'h0001); step();
        chk("pkt_first_data", 32'(out_data), 1);
        chk("pkt_first_vc",   32'(out_vc), 1);
        net_flit = mk(1'b1, 1'b0, 16'h00A0); step();
        chk("pkt_hold_data",  32'(out_data), 1);
        net_flit = mk(1'b0, 1'b1, 16'h0002); step();
        net_flit = mk(1'b1, 1'b1, 16'h0003); step();
        net_flit = '0;
        out_ready = 1'b1;
        chk("pkt0_data", 32'(out_data), 1);
        chk("pkt0_vc",   32'(out_vc), 1);
        chk("pkt0_tail", 32'(out_tail), 0);
        step();
        chk("pkt1_data", 32'(out_data), 2);
        chk("pkt1_vc",   32'(out_vc), 1);
        step();
        chk("pkt2_data", 32'(out_data), 3);
        chk("pkt2_tail", 32'(out_tail), 1);
        step();
        chk("pkt3_data", 32'(out_data), 32'hA0);
        chk("pkt3_vc",   32'(out_vc), 0);
        step();
        chk("pkt_done",  32'(out_valid), 0);

        // backpressure fill of VC0
        out_ready = 1'b0;
        net_flit = mk(1'b1, 1'b0, 16'h0010); step();
        chk("bp1_nonfull", 32'(net_nonfull), 3);
        net_flit = mk(1'b1, 1'b0, 16'h0011); step();
        chk("bp2_nonfull", 32'(net_nonfull), 3);
        net_flit = mk(1'b1, 1'b0, 16'h0012); step();
        chk("bp3_nonfull", 32'(net_nonfull), 2);
        net_flit = mk(1'b1, 1'b0, 16'h0013); step();
        net_flit = '0;
        chk("bp4_ovf",     32'(err_overflow), 0);
        chk("bp4_nonfull", 32'(net_nonfull), 2);
        chk("bp4_data",    32'(out_data), 32'h10);

        // push and pop on a full FIFO in the same cycle
        out_ready = 1'b1;
        net_flit  = mk(1'b1, 1'b0, 16'h0015);
        chk("sim_head", 32'(out_data), 32'h10);
        step();
        net_flit  = '0;
        out_ready = 1'b0;
        chk("sim_ovf",     32'(err_overflow), 0);
        chk("sim_nonfull", 32'(net_nonfull), 2);
        chk("sim_data",    32'(out_data), 32'h11);

        // overflow drops the flit
        net_flit = mk(1'b1, 1'b0, 16'h0014); step();
        net_flit = '0;
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_data", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        chk("drain1", 32'(out_data), 32'h12);
        step();
        chk("drain2", 32'(out_data), 32'h13);
        step();
        chk("drain3", 32'(out_data), 32'h15);
        step();
        chk("drain_empty",   32'(out_valid), 0);
        chk("drain_nonfull", 32'(net_nonfull), 3);
        chk("drain_ovf",     32'(err_overflow), 1);

        // reset while locked on VC1
        out_ready = 1'b0;
        net_flit = mk(1'b0, 1'b1, 16'h0021); step();
        net_flit = mk(1'b0, 1'b1, 16'h0022); step();
        net_flit = mk(1'b0, 1'b1, 16'h0023); step();
        net_flit = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        net_flit = mk(1'b1, 1'b0, 16'h0030); step();
        net_flit = '0;
        chk("lock_vc",   32'(out_vc), 1);
        chk("lock_data", 32'(out_data), 32'h22);
        #3;
        RST = 1'b1;
        #1;
        chk("mid_rst_valid",   32'(out_valid), 0);
        chk("mid_rst_data",    32'(out_data), 0);
        chk("mid_rst_vc",      32'(out_vc), 0);
        chk("mid_rst_get_en",  32'(net_get_en), 0);
        chk("mid_rst_nonfull", 32'(net_nonfull), 0);
        chk("mid_rst_ovf",     32'(err_overflow), 0);
        step();
        RST = 1'b0;
        step();
        chk("post_rst_nonfull", 32'(net_nonfull), 3);
        chk("post_rst_valid",   32'(out_valid), 0);

        out_ready = 1'b1;
        net_flit  = mk(1'b0, 1'b0, 16'h0040); step();
        chk("new0_valid", 32'(out_valid), 1);
        chk("new0_data",  32'(out_data), 32'h40);
        chk("new0_vc",    32'(out_vc), 0);
        chk("new0_tail",  32'(out_tail), 0);
        net_flit = mk(1'b1, 1'b0, 16'h0041); step();
        net_flit = '0;
        chk("new1_data",  32'(out_data), 32'h41);
        chk("new1_tail",  32'(out_tail), 1);
        step();
        chk("new_done",   32'(out_valid), 0);
        chk("dest_flag",  32'(err_dest), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
